// File: rtl/alu_sched_pkg.sv
// Shared constants and types for the round-robin ALU scheduler.
package alu_sched_pkg;

  localparam int OPND_W = 16;
  localparam int RES_W  = 32;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_NOTB = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/ALU.sv
// Combinational signed ALU: 16-bit operands, 32-bit sign-extended result.
// Division packs {quotient, remainder}; it has no divide-by-zero guard.
module ALU
  import alu_sched_pkg::*;
(
  input  logic signed [OPND_W-1:0] A,
  input  logic signed [OPND_W-1:0] B,
  input  logic        [2:0]        OP,
  output logic signed [RES_W-1:0]  RESULT
);

  logic signed [RES_W-1:0]  a_ext;
  logic signed [RES_W-1:0]  b_ext;
  logic signed [OPND_W-1:0] quot;
  logic signed [OPND_W-1:0] rem;

  // Sign-extend operands and select the operation result
  always_comb begin
    a_ext  = {{(RES_W-OPND_W){A[OPND_W-1]}}, A};
    b_ext  = {{(RES_W-OPND_W){B[OPND_W-1]}}, B};
    quot   = A / B;
    rem    = A % B;
    RESULT = '0;
    case (OP)
      OP_ADD:  RESULT = a_ext + b_ext;
      OP_SUB:  RESULT = a_ext - b_ext;
      OP_MUL:  RESULT = a_ext * b_ext;
      OP_DIV:  RESULT = {quot, rem};
      OP_OR:   RESULT = a_ext | b_ext;
      OP_AND:  RESULT = a_ext & b_ext;
      OP_NOTA: RESULT = ~a_ext;
      default: RESULT = ~b_ext;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from last_grant+1 with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic found;
  int   idx;

  // Pick the first requester after the previous winner
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU among NUM_REQ requesters: round-robin accept, one EXEC
// cycle on registered operands, then a tagged response held until taken.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OPND_W-1:0] req_a,
  input  logic [NUM_REQ*OPND_W-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]      req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [RES_W-1:0]          rsp_result,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_err,
  output logic                      busy
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic [OPND_W-1:0]   op_a_q, op_a_d;
  logic [OPND_W-1:0]   op_b_q, op_b_d;
  logic [2:0]          op_code_q, op_code_d;
  logic [ID_W-1:0]     op_id_q, op_id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0]    rsp_result_q, rsp_result_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic                rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic [RES_W-1:0]    alu_result;
  logic                div_by_zero;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  ALU u_alu (
    .A      (op_a_q),
    .B      (op_b_q),
    .OP     (op_code_q),
    .RESULT (alu_result)
  );

  assign div_by_zero = (op_code_q == OP_DIV) && (op_b_q == '0);

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != S_IDLE);

  // Next-state, operand capture and response generation
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_code_d    = op_code_q;
    op_id_d      = op_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    req_ready    = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = grant;
        if (|(req_valid & grant)) begin
          op_a_d       = req_a[grant_idx*OPND_W +: OPND_W];
          op_b_d       = req_b[grant_idx*OPND_W +: OPND_W];
          op_code_d    = req_op[grant_idx*3 +: 3];
          op_id_d      = grant_idx;
          last_grant_d = grant_idx;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = op_id_q;
        if (div_by_zero) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
        end else begin
          rsp_result_d = alu_result;
          rsp_err_d    = 1'b0;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_code_q    <= '0;
      op_id_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_code_q    <= op_code_d;
      op_id_q      <= op_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler: directed cases followed by
// randomized rounds, all checked against a behavioural model.
module tb_alu_rr_scheduler;
  import alu_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*16-1:0] req_a = '0;
  logic [NUM_REQ*16-1:0] req_b = '0;
  logic [NUM_REQ*3-1:0] req_op = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [31:0]          rsp_result;
  logic [ID_W-1:0]      rsp_id;
  logic                 rsp_err;
  logic                 busy;

  int checks = 0;
  int errors = 0;
  int lastGrant = NUM_REQ - 1;

  alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Hard stop in case something stalls the sequence
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference arithmetic straight from the opcode table, using int math
  function automatic logic [31:0] modelResult(input logic [15:0] a, input logic [15:0] b,
                                               input logic [2:0] op, output logic err);
    int sa, sb, q, r;
    logic [31:0] res;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    err = 1'b0;
    res = 32'd0;
    case (op)
      3'd0: res = sa + sb;
      3'd1: res = sa - sb;
      3'd2: res = sa * sb;
      3'd3: begin
        if (sb == 0) begin
          err = 1'b1;
          res = 32'd0;
        end else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {q[15:0], r[15:0]};
        end
      end
      3'd4: res = sa | sb;
      3'd5: res = sa & sb;
      3'd6: res = ~sa;
      default: res = ~sb;
    endcase
    return res;
  endfunction

  // Round-robin winner: first valid requester after the last grant
  function automatic int modelWinner(input logic [NUM_REQ-1:0] mask);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (mask[(lastGrant + k) % NUM_REQ]) return (lastGrant + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic setReq(input int i, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_op[3*i +: 3]  = op;
  endtask

  task automatic resetDut();
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst_n     = 1'b1;
    lastGrant = NUM_REQ - 1;
    tick();
  endtask

  task automatic checkResp(input int g, input logic [31:0] expRes, input logic expErr);
    checkOutput("resp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("resp_result", rsp_result, expRes);
    checkOutput("resp_id", 32'(rsp_id), 32'(g));
    checkOutput("resp_err", 32'(rsp_err), 32'(expErr));
    checkOutput("resp_req_ready", 32'(req_ready), 32'd0);
    checkOutput("resp_busy", 32'(busy), 32'd1);
  endtask

  // One arbitration round starting in IDLE: grant, EXEC, RESP (with
  // optional backpressure), back to IDLE
  task automatic applyStimulus(input logic [NUM_REQ-1:0] mask, input int hold, input bit keepValid);
    int g;
    logic [31:0] expRes;
    logic expErr;
    req_valid = mask;
    rsp_ready = (hold == 0);
    #1;
    g = modelWinner(mask);
    checkOutput("idle_req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    checkOutput("idle_busy", 32'(busy), 32'd0);
    if (g < 0) begin
      tick();
      return;
    end
    expRes = modelResult(req_a[16*g +: 16], req_b[16*g +: 16], req_op[3*g +: 3], expErr);
    tick();
    lastGrant = g;
    if (!keepValid) req_valid = '0;
    checkOutput("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("exec_busy", 32'(busy), 32'd1);
    checkOutput("exec_req_ready", 32'(req_ready), 32'd0);
    tick();
    checkResp(g, expRes, expErr);
    if (hold > 0) begin
      for (int k = 1; k < hold; k++) begin
        tick();
        checkResp(g, expRes, expErr);
      end
      rsp_ready = 1'b1;
    end
    tick();
    checkOutput("release_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("release_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    $display("[TB] start");
    resetDut();

    // Reset values
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_result", rsp_result, 32'd0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    // Single add from requester 1: 5 + -3
    setReq(1, 16'd5, 16'hFFFD, OP_ADD);
    applyStimulus(4'b0010, 0, 1'b0);
    checkOutput("add_literal", rsp_result, 32'h0000_0002);

    // All four continuously valid with multiply: order 0,1,2,3,0
    resetDut();
    for (int i = 0; i < NUM_REQ; i++) setReq(i, 16'(i + 1), 16'd100, OP_MUL);
    for (int k = 0; k < 5; k++) applyStimulus(4'b1111, 0, 1'b1);
    checkOutput("mul_wrap_id", 32'(rsp_id), 32'd0);
    req_valid = '0;

    // Signed division and divide-by-zero
    setReq(2, 16'hFFF9, 16'd2, OP_DIV);
    applyStimulus(4'b0100, 0, 1'b0);
    checkOutput("div_literal", rsp_result, 32'hFFFD_FFFF);
    setReq(2, 16'hFFF9, 16'd0, OP_DIV);
    applyStimulus(4'b0100, 0, 1'b0);
    checkOutput("div0_err", 32'(rsp_err), 32'd1);

    // Backpressure for five cycles
    setReq(0, 16'd1234, 16'd55, OP_SUB);
    applyStimulus(4'b0001, 5, 1'b0);

    // Reset during EXEC drops the operation and rewinds the pointer
    setReq(3, 16'd9, 16'd9, OP_ADD);
    req_valid = 4'b1000;
    #1;
    tick();
    req_valid = '0;
    checkOutput("mid_exec_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    checkOutput("mid_rst_hold_valid", 32'(rsp_valid), 32'd0);
    rst_n     = 1'b1;
    lastGrant = NUM_REQ - 1;
    tick();
    checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    setReq(0, 16'd3, 16'd4, OP_OR);
    setReq(2, 16'd6, 16'd3, OP_AND);
    applyStimulus(4'b0101, 0, 1'b0);
    checkOutput("post_rst_first_id", 32'(rsp_id), 32'd0);
    applyStimulus(4'b0100, 0, 1'b0);

    // Bitwise inversions
    setReq(1, 16'h00F0, 16'd7, OP_NOTA);
    applyStimulus(4'b0010, 0, 1'b0);
    checkOutput("nota_literal", rsp_result, 32'hFFFF_FF0F);
    setReq(1, 16'd0, 16'hFFFF, OP_NOTB);
    applyStimulus(4'b0010, 0, 1'b0);
    checkOutput("notb_literal", rsp_result, 32'h0000_0000);

    // Randomized rounds
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        logic [15:0] rb;
        rb = 16'($urandom);
        if ($urandom_range(0, 3) == 0) rb = 16'd0;
        setReq(i, 16'($urandom), rb, 3'($urandom_range(0, 7)));
      end
      applyStimulus(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
